hazard_forward_unit: RTL
========================

// Module: hazard_forward_unit
// PURPOSE
//   Tracks destination registers of in-flight instructions through EX/MEM/WB for the
//   5-stage MIPS datapath. Produces the load-use stall and the ALU operand forwarding
//   selects for the instruction in EX.
//   Sits beside the ID/EX pipeline register and is driven by the decode-stage fields.
// PARAMETERS
//   REG_BITS   5    register-number width; register 0 is never a hazard source
//   STAT_BITS  16   stall-counter width (HAZARD_STATS_EN only)
// PORTS
//   clk          in   1         rising-edge clock; the only clock
//   rst          in   1         synchronous, active-high reset
//   id_valid     in   1         ID holds a real instruction
//   id_rs        in   REG_BITS  ID source register A
//   id_rt        in   REG_BITS  ID source register B
//   id_rd        in   REG_BITS  ID destination register
//   id_regwrite  in   1         ID instruction writes id_rd
//   id_memread   in   1         ID instruction is a load
//   flush        in   1         squash the instruction in ID (branch taken)
//   stall        out  1         hold PC and IF/ID; insert a bubble into EX
//   fwd_a        out  2         EX operand A select: 00 regfile, 10 MEM result, 01 WB result
//   fwd_b        out  2         EX operand B select, same encoding
//   stall_count  out  STAT_BITS cumulative stall cycles (HAZARD_STATS_EN only)
// BEHAVIOUR
//   - Internal stage records ex_, mem_, wb_: {valid, rs, rt, rd, regwrite, memread}.
//   - Reset: all records cleared to valid=0, regwrite=0; stall=0; fwd_a=fwd_b=00.
//     Reset mid-operation discards every in-flight record in the same edge.
//   - "Writer" in a stage: valid & regwrite & rd!=0.
//   - stall (combinational): id_valid & !flush & ex writer & ex_memread &
//     (ex_rd==id_rs | ex_rd==id_rt). Held low while rst=1.
//   - Each edge: mem<=ex, wb<=mem. ex<=ID fields if id_valid & !stall & !flush;
//     otherwise ex<=bubble (valid=0).
//   - A stall lasts exactly 1 cycle. The bubble removes the EX load match; upstream
//     holds ID, so the dependent then reaches EX with the load in WB (fwd=01).
//   - fwd_a: 10 if mem writer & mem_rd==ex_rs; else 01 if wb writer & wb_rd==ex_rs;
//     else 00. fwd_b is identical using ex_rt. MEM has priority over WB.
//     Both are functions of registered state only.
//   - A non-valid EX record forces fwd_a=fwd_b=00.
//   - flush & stall condition in the same cycle: flush wins; stall=0 and a bubble enters EX.
//   - The same register on rs and rt is legal; both selects assert.
//   - WB-to-ID same-cycle writes are handled by the regfile write-first rule, not here.
// CONFIGURATION
//   HAZARD_STATS_EN defined: stall_count resets to 0 and increments on each cycle with
//     stall=1, saturating at all-ones.
//   HAZARD_STATS_EN undefined: the stall_count port and counter are absent; all other
//     behaviour is unchanged.
// STRUCTURE
//   hazard_pkg: FWD_NONE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10; stage_rec_t record typedef;
//     BUBBLE constant.
//   Sub-module reg_match_nz (REG_BITS): Y = (a==b) & (a!=0). Instantiated 6x: 2 stall
//     compares and 4 forwarding compares.
// TESTING
//   1 rst=1 for 2 cycles, then idle -> stall=0, fwd_a=fwd_b=00, stall_count=0.
//   2 add $3 then sub $5,$3,$4 issued back to back -> with sub in EX: fwd_a=10, fwd_b=00.
//   3 add $3, nop, then or $6,$4,$3 -> with or in EX: fwd_b=01.
//     Add $3 then add $3 then use $3 -> fwd=10 (MEM wins).
//   4 lw $2 then and $7,$2,$2 -> stall=1 for exactly 1 cycle, then and in EX with
//     fwd_a=fwd_b=01; stall_count=1.
//   5 lw $2 then flush with dependent in ID -> stall=0 and bubble in EX. Separately,
//     add $0 followed by use of $0 -> fwd=00 and no stall.
//   6 rst asserted with a load in EX and dependent in ID -> next cycle stall=0,
//     fwd=00, stall_count=0.

Source files
------------

// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_pkg
// Purpose  : Shared types and constants for the hazard/forwarding unit:
//            forwarding-select encodings, the per-stage record and the
//            bubble constant.
// Revision : 1.0 - initial release
// ============================================================================
package hazard_pkg;

  // Register-number width that the stage record is built with.
  localparam int REG_BITS_DFLT = 5;

  // EX operand source selects.
  localparam logic [1:0] FWD_NONE = 2'b00;  // register file value
  localparam logic [1:0] FWD_WB   = 2'b01;  // result sitting in WB
  localparam logic [1:0] FWD_MEM  = 2'b10;  // result sitting in MEM

  // What the unit remembers about the instruction occupying a stage.
  typedef struct packed {
    logic                     valid;
    logic [REG_BITS_DFLT-1:0] rs;
    logic [REG_BITS_DFLT-1:0] rt;
    logic [REG_BITS_DFLT-1:0] rd;
    logic                     regwrite;
    logic                     memread;
  } stage_rec_t;

  // Empty slot: no instruction, writes nothing.
  localparam stage_rec_t BUBBLE = stage_rec_t'('0);

  // A stage produces a value worth forwarding only if it is real, writes,
  // and does not target the hard-wired zero register.
  function automatic logic is_writer(input stage_rec_t rec);
    return rec.valid & rec.regwrite & (rec.rd != '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_match_nz.sv
`default_nettype none
// ============================================================================
// Module   : reg_match_nz
// Purpose  : Register-number comparator that never reports a match on
//            register 0 (y = (a == b) & (a != 0)).
// Revision : 1.0 - initial release
// ============================================================================
module reg_match_nz #(
  parameter int REG_BITS = 5
) (
  input  logic [REG_BITS-1:0] a,
  input  logic [REG_BITS-1:0] b,
  output logic                y
);

  // Equality qualified by a non-zero register number.
  always_comb begin
    y = (a == b) && (a != '0);
  end

endmodule
`default_nettype wire

// File: rtl/hazard_forward_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_forward_unit
// Purpose  : Tracks destination registers of in-flight instructions through
//            EX/MEM/WB of a 5-stage MIPS pipeline; generates the load-use
//            stall and the EX operand forwarding selects.
// Config   : HAZARD_STATS_EN - when defined, adds the saturating stall_count
//            output (STAT_BITS wide).
// Revision : 1.0 - initial release
// ============================================================================
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int REG_BITS = REG_BITS_DFLT
`ifdef HAZARD_STATS_EN
  , parameter int STAT_BITS = 16
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [REG_BITS-1:0] id_rs,
  input  logic [REG_BITS-1:0] id_rt,
  input  logic [REG_BITS-1:0] id_rd,
  input  logic                id_regwrite,
  input  logic                id_memread,
  input  logic                flush,
  output logic                stall,
  output logic [1:0]          fwd_a,
  output logic [1:0]          fwd_b
`ifdef HAZARD_STATS_EN
  , output logic [STAT_BITS-1:0] stall_count
`endif
);

  // Stage records; the record width follows the package register width.
  stage_rec_t ex_q,  ex_d;
  stage_rec_t mem_q, mem_d;
  stage_rec_t wb_q,  wb_d;

  logic stall_rs_hit, stall_rt_hit;
  logic mem_rs_hit, mem_rt_hit, wb_rs_hit, wb_rt_hit;

  // Load in EX against the sources of the instruction in ID.
  reg_match_nz #(.REG_BITS(REG_BITS)) u_stall_rs (.a(ex_q.rd),  .b(id_rs),   .y(stall_rs_hit));
  reg_match_nz #(.REG_BITS(REG_BITS)) u_stall_rt (.a(ex_q.rd),  .b(id_rt),   .y(stall_rt_hit));
  // Older producers in MEM / WB against the sources of the instruction in EX.
  reg_match_nz #(.REG_BITS(REG_BITS)) u_mem_rs   (.a(mem_q.rd), .b(ex_q.rs), .y(mem_rs_hit));
  reg_match_nz #(.REG_BITS(REG_BITS)) u_mem_rt   (.a(mem_q.rd), .b(ex_q.rt), .y(mem_rt_hit));
  reg_match_nz #(.REG_BITS(REG_BITS)) u_wb_rs    (.a(wb_q.rd),  .b(ex_q.rs), .y(wb_rs_hit));
  reg_match_nz #(.REG_BITS(REG_BITS)) u_wb_rt    (.a(wb_q.rd),  .b(ex_q.rt), .y(wb_rt_hit));

  // Load-use stall; a flush squashes the consumer so it takes precedence,
  // and the stall is held off while reset is asserted.
  always_comb begin
    stall = 1'b0;
    if (!rst && id_valid && !flush && is_writer(ex_q) && ex_q.memread &&
        (stall_rs_hit || stall_rt_hit)) begin
      stall = 1'b1;
    end
  end

  // Pipeline advance: ID enters EX unless stalled or squashed, in which case
  // a bubble is inserted; MEM and WB simply follow.
  always_comb begin
    ex_d = BUBBLE;
    if (id_valid && !stall && !flush) begin
      ex_d.valid    = 1'b1;
      ex_d.rs       = id_rs;
      ex_d.rt       = id_rt;
      ex_d.rd       = id_rd;
      ex_d.regwrite = id_regwrite;
      ex_d.memread  = id_memread;
    end
    mem_d = ex_q;
    wb_d  = mem_q;
  end

  // Stage record registers; reset discards every in-flight record.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= BUBBLE;
      mem_q <= BUBBLE;
      wb_q  <= BUBBLE;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  // Forwarding selects from registered state only; MEM is the younger
  // producer and therefore wins over WB.
  always_comb begin
    fwd_a = FWD_NONE;
    fwd_b = FWD_NONE;
    if (ex_q.valid) begin
      if (is_writer(mem_q) && mem_rs_hit)     fwd_a = FWD_MEM;
      else if (is_writer(wb_q) && wb_rs_hit)  fwd_a = FWD_WB;
      if (is_writer(mem_q) && mem_rt_hit)     fwd_b = FWD_MEM;
      else if (is_writer(wb_q) && wb_rt_hit)  fwd_b = FWD_WB;
    end
  end

  // Source fields and the load flag of MEM/WB records travel along but are
  // never consulted once the instruction has left EX.
  logic unused_rec_bits;
  assign unused_rec_bits = ^{mem_q.rs, mem_q.rt, mem_q.memread,
                             wb_q.rs,  wb_q.rt,  wb_q.memread};

`ifdef HAZARD_STATS_EN
  logic [STAT_BITS-1:0] stall_count_q, stall_count_d;

  // Count stall cycles, sticking at all-ones.
  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + 1'b1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (rst) stall_count_q <= '0;
    else     stall_count_q <= stall_count_d;
  end

  assign stall_count = stall_count_q;
`endif

endmodule
`default_nettype wire
